// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the streaming adder accumulator.
package adder_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned COUNT_DEF  = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Accumulator width that cannot overflow when summing count full-scale samples.
    function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned count);
        return data_w + $clog2(count);
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Plain W-bit combinational adder; carry out of the top bit is discarded.
module adder_nbit #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_c
);

    assign sum_c = a_i + b_i;

endmodule

// File: rtl/adder_accum_32bit.sv
// Batch accumulator: sums COUNT handshaked samples and holds the total until accepted.
// Define ADDER_ACCUM_AVG_EN to output the floor mean instead of the full sum.
module adder_accum_32bit
    import adder_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned COUNT  = COUNT_DEF,
    localparam int unsigned ACC_W  = acc_width(DATA_W, COUNT),
    localparam int unsigned IDX_W  = $clog2(COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_last_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

    acc_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [ACC_W-1:0]  sum_c;
    logic [ACC_W-1:0]  result_c;
    logic              in_xfer_c;

    adder_nbit #(
        .W (ACC_W)
    ) u_acc_add (
        .a_i   (acc_q),
        .b_i   (ACC_W'(in_data)),
        .sum_c (sum_c)
    );

`ifdef ADDER_ACCUM_AVG_EN
    assign result_c = sum_c >> IDX_W;
`else
    assign result_c = sum_c;
`endif

    assign in_xfer_c = in_valid && in_ready_q;

    // Next-state: accumulate in ACCUM, park the total in HOLD until the consumer takes it.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ACCUM: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (clr) begin
                    acc_d = '0;
                    idx_d = '0;
                end else if (in_xfer_c) begin
                    if (idx_q == LAST_IDX) begin
                        out_data_d  = result_c;
                        acc_d       = '0;
                        idx_d       = '0;
                        state_d     = HOLD;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d = sum_c;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                if (out_ready) begin
                    state_d     = ACCUM;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ACCUM;
                acc_d       = '0;
                idx_d       = '0;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last_idx = idx_q;

endmodule
